// File: rtl/reg_cfg_seq_pkg.sv
// rtl/reg_cfg_seq_pkg.sv - shared types and constants for the register configuration sequencer
package reg_cfg_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_COPY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int NUM_A    = 5;
    localparam int NUM_B    = 3;
    localparam int NUM_REGS = NUM_A + NUM_B;

    localparam int A_BASE = 0;
    localparam int B_BASE = A_BASE + NUM_A;

    // Addresses at or above this value are outside the bank.
    localparam logic [3:0] ADDR_END = 4'(NUM_REGS);

    localparam logic [2:0] LAST_IDX = 3'(NUM_REGS - 1);

endpackage

// File: rtl/reg_cfg_seq.sv
// rtl/reg_cfg_seq.sv - shadow register bank with a sequenced, one-register-per-cycle commit to live outputs
module reg_cfg_seq
    import reg_cfg_seq_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wr_valid,
    output logic          o_wr_ready,
    input  logic [3:0]    i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_commit,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic [DW-1:0] reg_a_0,
    output logic [DW-1:0] reg_a_1,
    output logic [DW-1:0] reg_a_2,
    output logic [DW-1:0] reg_a_3,
    output logic [DW-1:0] reg_a_4,
    output logic [DW-1:0] reg_b_0,
    output logic [DW-1:0] reg_b_1,
    output logic [DW-1:0] reg_b_2
);

    state_e        state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic          err_q;
    logic [DW-1:0] shadow_q [NUM_REGS];
    logic [DW-1:0] live_q   [NUM_REGS];

    logic wr_fire;
    logic addr_valid;
    logic copy_en;

    assign o_wr_ready = (state_q == ST_IDLE);
    assign o_busy     = (state_q != ST_IDLE);
    assign o_done     = (state_q == ST_DONE);
    assign o_err      = err_q;

    assign wr_fire    = i_wr_valid && o_wr_ready;
    assign addr_valid = (i_wr_addr < ADDR_END);
    assign copy_en    = (state_q == ST_COPY);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                idx_d = 3'd0;
                if (i_commit) begin
                    state_d = ST_COPY;
                end
            end
            ST_COPY: begin
                // idx holds at the last entry rather than wrapping to 0.
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                idx_d   = 3'd0;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            err_q   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= '0;
                live_q[i]   <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= wr_fire && !addr_valid;
            if (wr_fire && addr_valid) begin
                shadow_q[i_wr_addr[2:0]] <= i_wr_data;
            end
            if (copy_en) begin
                live_q[idx_q] <= shadow_q[idx_q];
            end
        end
    end

    assign reg_a_0 = live_q[0];
    assign reg_a_1 = live_q[1];
    assign reg_a_2 = live_q[2];
    assign reg_a_3 = live_q[3];
    assign reg_a_4 = live_q[4];
    assign reg_b_0 = live_q[5];
    assign reg_b_1 = live_q[6];
    assign reg_b_2 = live_q[7];

endmodule

// File: tb/tb_reg_cfg_seq.sv
// tb/tb_reg_cfg_seq.sv - directed and randomized checks of reg_cfg_seq against a cycle-count reference model
module tb_reg_cfg_seq;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          wv;
    logic          cm;
    logic [3:0]    wa;
    logic [DW-1:0] wd;

    logic          wr_ready, busy, done, err;
    logic [DW-1:0] ra0, ra1, ra2, ra3, ra4, rb0, rb1, rb2;
    logic [DW-1:0] dut_lv [8];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: shadow/live arrays, a commit snapshot and edges elapsed since the commit.
    logic [DW-1:0] m_sh [8];
    logic [DW-1:0] m_lv [8];
    logic [DW-1:0] m_sn [8];
    int            m_t;
    logic          m_err;

    always #5 clk = ~clk;

    reg_cfg_seq #(.DW(DW)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_wr_valid (wv),
        .o_wr_ready (wr_ready),
        .i_wr_addr  (wa),
        .i_wr_data  (wd),
        .i_commit   (cm),
        .o_busy     (busy),
        .o_done     (done),
        .o_err      (err),
        .reg_a_0    (ra0),
        .reg_a_1    (ra1),
        .reg_a_2    (ra2),
        .reg_a_3    (ra3),
        .reg_a_4    (ra4),
        .reg_b_0    (rb0),
        .reg_b_1    (rb1),
        .reg_b_2    (rb2)
    );

    assign dut_lv[0] = ra0;
    assign dut_lv[1] = ra1;
    assign dut_lv[2] = ra2;
    assign dut_lv[3] = ra3;
    assign dut_lv[4] = ra4;
    assign dut_lv[5] = rb0;
    assign dut_lv[6] = rb1;
    assign dut_lv[7] = rb2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic v, input logic [3:0] a,
                              input logic [DW-1:0] d, input logic c);
        bit ready;
        if (r) begin
            for (int i = 0; i < 8; i++) begin
                m_sh[i] = '0;
                m_lv[i] = '0;
                m_sn[i] = '0;
            end
            m_t   = 0;
            m_err = 1'b0;
        end else begin
            ready = (m_t == 0);
            m_err = ready && v && (a >= 8);
            if (ready && v && a < 8) m_sh[a] = d;
            if (m_t >= 1 && m_t <= 8) begin
                m_lv[m_t-1] = m_sn[m_t-1];
                m_t++;
            end else if (m_t == 9) begin
                m_t = 0;
            end else if (c) begin
                for (int i = 0; i < 8; i++) m_sn[i] = m_sh[i];
                m_t = 1;
            end
        end
    endtask

    task automatic cyc(input logic r, input logic v, input logic [3:0] a,
                       input logic [DW-1:0] d, input logic c);
        rst = r; wv = v; wa = a; wd = d; cm = c;
        @(posedge clk);
        model_edge(r, v, a, d, c);
        #1;
        chk("wr_ready", 32'(wr_ready), 32'(m_t == 0));
        chk("busy",     32'(busy),     32'(m_t != 0));
        chk("done",     32'(done),     32'(m_t == 9));
        chk("err",      32'(err),      32'(m_err));
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("live%0d", i), 32'(dut_lv[i]), 32'(m_lv[i]));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'd0, '0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; wv = 1'b0; wa = '0; wd = '0; cm = 1'b0;
        m_t = 0; m_err = 1'b0;

        cyc(1'b1, 1'b0, 4'd0, '0, 1'b0);
        cyc(1'b1, 1'b1, 4'd2, 8'h33, 1'b1);
        idle(2);

        // Fill shadow with no commit: live stays zero.
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 4'(i), 8'(8'h10 + i), 1'b0);
        idle(3);

        // Full commit sequence.
        cyc(1'b0, 1'b0, 4'd0, '0, 1'b1);
        idle(11);

        // Write coinciding with commit is included.
        cyc(1'b0, 1'b1, 4'd3, 8'hAA, 1'b1);
        idle(11);

        // Invalid address.
        cyc(1'b0, 1'b1, 4'd12, 8'h55, 1'b0);
        idle(2);
        cyc(1'b0, 1'b1, 4'd15, 8'h66, 1'b0);
        cyc(1'b0, 1'b0, 4'd0, '0, 1'b1);
        idle(11);

        // Commit and writes while busy are ignored.
        cyc(1'b0, 1'b0, 4'd0, '0, 1'b1);
        for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 4'(i % 8), 8'hEE, 1'b1);
        idle(3);
        cyc(1'b0, 1'b0, 4'd0, '0, 1'b1);
        idle(11);

        // Reset at T+4 of a commit aborts it.
        cyc(1'b0, 1'b0, 4'd0, '0, 1'b1);
        idle(3);
        cyc(1'b1, 1'b1, 4'd1, 8'h77, 1'b1);
        idle(12);

        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 2) != 0),
                4'($urandom_range(0, 15)),
                8'($urandom),
                ($urandom_range(0, 14) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
